// File: rtl/irq_csr_unit.sv
// irq_csr_unit
// Machine-mode CSR file and interrupt sequencer for the 5-stage core.
// It holds mstatus, mie, mip, mtvec, mepc, mcause and mscratch, plus a
// 64-bit mcycle counter. MEI, MSI, MTI and the local lines are arbitrated
// by fixed priority, and each taken interrupt runs a three-state
// IDLE/TAKE/SETTLE sequence.
//
// Ports
//   clk_i, reset_i  clock; synchronous active-high reset
//   pc_i            PC of the oldest uncommitted instruction (saved to mepc)
//   csr_r_addr_i    CSR read address; csr_rdata_o follows one cycle later
//   csr_w_addr_i, csr_wdata_i, csr_wen_i
//                   CSR write port
//   mret_i          an mret is retiring this cycle
//   irq_ready_i     the pipeline can accept a trap this cycle
//   meip_i, msip_i, mtip_i, lirq_i
//                   level-sensitive interrupt requests
//   trap_o          one-cycle redirect/flush pulse
//   trap_addr_o     redirect target while trap_o=1, otherwise 0
//   mepc_o          current mepc, used for the mret redirect
//   irq_ack_o       one-hot accepted source: MEI, MSI, MTI, then local i
//
// Handshake: the FSM accepts an interrupt only in a cycle where
// irq_ready_i=1. It then asserts trap_o and irq_ack_o for exactly one cycle.
// No back-pressure applies to that pulse.
module irq_csr_unit #(
  parameter int NUM_LOCAL_IRQ = 4,
  parameter bit VECTORED_EN   = 1'b1,
  parameter bit MCYCLE_EN     = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [31:0]                pc_i,
  input  logic [11:0]                csr_r_addr_i,
  input  logic [11:0]                csr_w_addr_i,
  input  logic [31:0]                csr_wdata_i,
  input  logic                       csr_wen_i,
  input  logic                       mret_i,
  input  logic                       irq_ready_i,
  input  logic                       meip_i,
  input  logic                       msip_i,
  input  logic                       mtip_i,
  input  logic [NUM_LOCAL_IRQ-1:0]   lirq_i,
  output logic [31:0]                csr_rdata_o,
  output logic                       trap_o,
  output logic [31:0]                trap_addr_o,
  output logic [31:0]                mepc_o,
  output logic [NUM_LOCAL_IRQ+2:0]   irq_ack_o
);

  localparam int ACK_W = NUM_LOCAL_IRQ + 3;
  localparam logic [31:0] LOCAL_MASK = ((32'h1 << NUM_LOCAL_IRQ) - 32'h1) << 16;
  localparam logic [31:0] MIE_MASK   = 32'h0000_0888 | LOCAL_MASK;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TAKE   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             mst_mie_q, mst_mpie_q;
  logic [31:0]      mie_q, mip_q, mip_d;
  logic [31:0]      mtvec_q, mepc_q, mcause_q, mscratch_q;
  logic [63:0]      mcycle_q;
  logic [31:0]      rdata_q, rdata_d;
  logic [4:0]       cause_q, win_cause;
  logic [ACK_W-1:0] ack_q, win_ack;
  logic [31:0]      pend_vec;
  logic             pend, accept, in_take;
  logic [31:0]      tvec_base;
  logic             vec_mode;

  // Raw request lines placed at their mip bit positions.
  always_comb begin
    mip_d = 32'h0;
    mip_d[11] = meip_i;
    mip_d[3]  = msip_i;
    mip_d[7]  = mtip_i;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
      mip_d[16+i] = lirq_i[i];
    end
  end

  assign pend_vec = mip_q & mie_q;
  assign pend     = mst_mie_q & (|pend_vec);

  // Fixed-priority arbiter. The local lines are scanned from the highest
  // index down, so the lowest pending index is the one left assigned.
  always_comb begin
    logic [4:0]       lo_cause;
    logic [ACK_W-1:0] lo_ack;
    lo_cause  = 5'd0;
    lo_ack    = '0;
    win_cause = 5'd0;
    win_ack   = '0;
    for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
      if (pend_vec[16+i]) begin
        lo_cause  = 5'(16 + i);
        lo_ack    = '0;
        lo_ack[3+i] = 1'b1;
      end
    end
    if (pend_vec[11]) begin
      win_cause  = 5'd11;
      win_ack[0] = 1'b1;
    end else if (pend_vec[3]) begin
      win_cause  = 5'd3;
      win_ack[1] = 1'b1;
    end else if (pend_vec[7]) begin
      win_cause  = 5'd7;
      win_ack[2] = 1'b1;
    end else begin
      win_cause = lo_cause;
      win_ack   = lo_ack;
    end
  end

  // An mret in the same cycle wins. The interrupt is then re-evaluated
  // next cycle against the restored MIE.
  assign accept  = (state_q == ST_IDLE) && pend && irq_ready_i && !mret_i;
  assign in_take = (state_q == ST_TAKE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_TAKE;
      ST_TAKE:   state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cause_q <= 5'd0;
      ack_q   <= '0;
      mip_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      mip_q   <= mip_d;
      if (accept) begin
        cause_q <= win_cause;
        ack_q   <= win_ack;
      end
    end
  end

  // The trap update owns mstatus, mepc and mcause. A software write to any
  // of those in the TAKE cycle is dropped. Writes to other CSRs still land.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= 32'h0;
      mtvec_q    <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mscratch_q <= 32'h0;
    end else begin
      if (in_take) begin
        mst_mpie_q <= mst_mie_q;
        mst_mie_q  <= 1'b0;
        mepc_q     <= pc_i & 32'hFFFF_FFFC;
        mcause_q   <= {1'b1, 26'd0, cause_q};
      end else begin
        if (mret_i) begin
          mst_mie_q  <= mst_mpie_q;
          mst_mpie_q <= 1'b1;
        end else if (csr_wen_i && csr_w_addr_i == A_MSTATUS) begin
          mst_mie_q  <= csr_wdata_i[3];
          mst_mpie_q <= csr_wdata_i[7];
        end
        if (csr_wen_i && csr_w_addr_i == A_MEPC)   mepc_q   <= csr_wdata_i & 32'hFFFF_FFFC;
        if (csr_wen_i && csr_w_addr_i == A_MCAUSE) mcause_q <= csr_wdata_i;
      end
      if (csr_wen_i && csr_w_addr_i == A_MIE)      mie_q      <= csr_wdata_i & MIE_MASK;
      if (csr_wen_i && csr_w_addr_i == A_MSCRATCH) mscratch_q <= csr_wdata_i;
      // Modes 2 and 3 are illegal and collapse to direct mode.
      if (csr_wen_i && csr_w_addr_i == A_MTVEC) begin
        mtvec_q <= {csr_wdata_i[31:2],
                    (VECTORED_EN && csr_wdata_i[1:0] == 2'b01) ? 2'b01 : 2'b00};
      end
    end
  end

  // A software write to either mcycle half replaces it and suppresses that
  // cycle's increment.
  always_ff @(posedge clk_i) begin
    if (reset_i || !MCYCLE_EN) begin
      mcycle_q <= 64'h0;
    end else if (csr_wen_i && csr_w_addr_i == A_MCYCLE) begin
      mcycle_q[31:0] <= csr_wdata_i;
    end else if (csr_wen_i && csr_w_addr_i == A_MCYCLEH) begin
      mcycle_q[63:32] <= csr_wdata_i;
    end else begin
      mcycle_q <= mcycle_q + 64'h1;
    end
  end

  always_comb begin
    rdata_d = 32'h0;
    case (csr_r_addr_i)
      A_MSTATUS:  rdata_d = {19'd0, 2'b11, 3'd0, mst_mpie_q, 3'd0, mst_mie_q, 3'd0};
      A_MIE:      rdata_d = mie_q;
      A_MTVEC:    rdata_d = mtvec_q;
      A_MSCRATCH: rdata_d = mscratch_q;
      A_MEPC:     rdata_d = mepc_q;
      A_MCAUSE:   rdata_d = mcause_q;
      A_MIP:      rdata_d = mip_q;
      A_MCYCLE:   rdata_d = mcycle_q[31:0];
      A_MCYCLEH:  rdata_d = mcycle_q[63:32];
      default:    rdata_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rdata_q <= 32'h0;
    else         rdata_q <= rdata_d;
  end

  assign tvec_base = {mtvec_q[31:2], 2'b00};
  assign vec_mode  = VECTORED_EN && (mtvec_q[1:0] == 2'b01);

  assign csr_rdata_o = rdata_q;
  assign trap_o      = in_take;
  assign irq_ack_o   = in_take ? ack_q : '0;
  assign trap_addr_o = !in_take ? 32'h0 :
                       vec_mode ? tvec_base + {25'd0, cause_q, 2'b00} : tvec_base;
  assign mepc_o      = mepc_q;

endmodule

// File: tb/tb_irq_csr_unit.sv
// Directed testbench for irq_csr_unit with hand-computed expected values.
module tb_irq_csr_unit;

  localparam int NL = 4;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [31:0]   pc_i;
  logic [11:0]   csr_r_addr_i, csr_w_addr_i;
  logic [31:0]   csr_wdata_i;
  logic          csr_wen_i, mret_i, irq_ready_i;
  logic          meip_i, msip_i, mtip_i;
  logic [NL-1:0] lirq_i;
  logic [31:0]   csr_rdata_o, trap_addr_o, mepc_o;
  logic          trap_o;
  logic [NL+2:0] irq_ack_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  irq_csr_unit #(.NUM_LOCAL_IRQ(NL), .VECTORED_EN(1'b1), .MCYCLE_EN(1'b1)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .pc_i(pc_i),
    .csr_r_addr_i(csr_r_addr_i), .csr_w_addr_i(csr_w_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_wen_i(csr_wen_i), .mret_i(mret_i),
    .irq_ready_i(irq_ready_i), .meip_i(meip_i), .msip_i(msip_i), .mtip_i(mtip_i),
    .lirq_i(lirq_i), .csr_rdata_o(csr_rdata_o), .trap_o(trap_o),
    .trap_addr_o(trap_addr_o), .mepc_o(mepc_o), .irq_ack_o(irq_ack_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_w_addr_i = addr;
    csr_wdata_i  = data;
    csr_wen_i    = 1'b1;
    tick();
    csr_wen_i    = 1'b0;
  endtask

  task automatic csr_read(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_r_addr_i = addr;
    exp_q.push_back(exp);
    tick();
    check_eq(tag, csr_rdata_o, exp_q.pop_front());
  endtask

  task automatic wait_trap(input string tag);
    int n;
    n = 0;
    while (!trap_o && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, trap_o}, 32'h1);
  endtask

  initial begin
    reset_i = 1'b1; pc_i = 32'h0000_1000;
    csr_r_addr_i = 12'h0; csr_w_addr_i = 12'h0; csr_wdata_i = 32'h0;
    csr_wen_i = 1'b0; mret_i = 1'b0; irq_ready_i = 1'b1;
    meip_i = 1'b0; msip_i = 1'b0; mtip_i = 1'b0; lirq_i = '0;
    tick();
    tick();
    check_eq("rst_rdata", csr_rdata_o, 32'h0);
    check_eq("rst_trap", {31'd0, trap_o}, 32'h0);
    check_eq("rst_ack", 32'(irq_ack_o), 32'h0);
    check_eq("rst_taddr", trap_addr_o, 32'h0);
    reset_i = 1'b0;
    csr_read("rst_mstatus", 12'h300, 32'h0000_1800);
    csr_read("rst_mip", 12'h344, 32'h0);

    // MEI with vectored mtvec, with the exact two-cycle latency checked.
    csr_write(12'h305, 32'h0000_0101);
    csr_write(12'h304, 32'h0000_0800);
    csr_write(12'h300, 32'h0000_0008);
    meip_i = 1'b1;
    tick();
    check_eq("lat_t1", {31'd0, trap_o}, 32'h0);
    tick();
    check_eq("lat_t2", {31'd0, trap_o}, 32'h1);
    check_eq("mei_addr", trap_addr_o, 32'h0000_012C);
    check_eq("mei_ack", 32'(irq_ack_o), 32'h01);
    meip_i = 1'b0;
    tick();
    check_eq("pulse_end", {31'd0, trap_o}, 32'h0);
    csr_read("mei_mcause", 12'h342, 32'h8000_000B);
    csr_read("mei_mepc", 12'h341, 32'h0000_1000);
    check_eq("mepc_o", mepc_o, 32'h0000_1000);
    csr_read("mei_mstatus", 12'h300, 32'h0000_1880);

    // Priority: MEI beats MTI and local 0. MTI is taken after mret.
    csr_write(12'h304, 32'h0001_0880);
    csr_write(12'h300, 32'h0000_0008);
    meip_i = 1'b1; mtip_i = 1'b1; lirq_i = 4'b0001;
    wait_trap("prio_trap1");
    check_eq("prio_ack1", 32'(irq_ack_o), 32'h01);
    meip_i = 1'b0;
    tick();
    csr_read("prio_mcause1", 12'h342, 32'h8000_000B);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    wait_trap("prio_trap2");
    check_eq("prio_ack2", 32'(irq_ack_o), 32'h04);
    check_eq("prio_addr2", trap_addr_o, 32'h0000_011C);
    mtip_i = 1'b0; lirq_i = '0;
    tick();
    csr_read("prio_mcause2", 12'h342, 32'h8000_0007);

    // Field masking, WARL mtvec and a registered mip.
    csr_write(12'h304, 32'hFFFF_FFFF);
    csr_read("mie_mask", 12'h304, 32'h000F_0888);
    csr_write(12'h344, 32'hFFFF_FFFF);
    csr_read("mip_ro", 12'h344, 32'h0);
    msip_i = 1'b1;
    tick();
    csr_read("mip_msip", 12'h344, 32'h0000_0008);
    msip_i = 1'b0;
    csr_write(12'h341, 32'h0000_1003);
    csr_read("mepc_align", 12'h341, 32'h0000_1000);
    csr_write(12'h340, 32'hDEAD_BEEF);
    csr_read("mscratch", 12'h340, 32'hDEAD_BEEF);
    csr_write(12'h305, 32'h0000_0203);
    csr_read("mtvec_warl", 12'h305, 32'h0000_0200);
    csr_read("unmapped", 12'h123, 32'h0);

    // Local irq 2 in vectored mode: cause 18 gives an offset of 0x48.
    csr_write(12'h305, 32'h0000_0201);
    csr_write(12'h304, 32'h0004_0000);
    csr_write(12'h300, 32'h0000_0008);
    lirq_i = 4'b0100;
    wait_trap("l2_trap");
    check_eq("l2_addr", trap_addr_o, 32'h0000_0248);
    check_eq("l2_ack", 32'(irq_ack_o), 32'h20);
    lirq_i = '0;
    tick();
    csr_read("l2_mcause", 12'h342, 32'h8000_0012);

    // irq_ready_i holds the trap off. Reset in TAKE aborts it.
    pc_i = 32'h0000_2000;
    irq_ready_i = 1'b0;
    csr_write(12'h304, 32'h0000_0008);
    csr_write(12'h300, 32'h0000_0008);
    msip_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("hold_%0d", i), {31'd0, trap_o}, 32'h0);
    end
    irq_ready_i = 1'b1;
    tick();
    check_eq("rel_trap", {31'd0, trap_o}, 32'h1);
    check_eq("rel_ack", 32'(irq_ack_o), 32'h02);
    check_eq("rel_addr", trap_addr_o, 32'h0000_020C);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0; msip_i = 1'b0;
    check_eq("abort_trap", {31'd0, trap_o}, 32'h0);
    csr_read("abort_mstatus", 12'h300, 32'h0000_1800);
    csr_read("abort_mepc", 12'h341, 32'h0);
    csr_read("abort_mcause", 12'h342, 32'h0);
    csr_read("abort_mie", 12'h304, 32'h0);
    csr_read("abort_mtvec", 12'h305, 32'h0);
    csr_read("abort_mscratch", 12'h340, 32'h0);

    // mcycle carries from the low half into the high half.
    csr_write(12'hB80, 32'h0);
    csr_write(12'hB00, 32'hFFFF_FFFF);
    csr_read("mcyc_pre", 12'hB00, 32'hFFFF_FFFF);
    csr_read("mcyc_lo", 12'hB00, 32'h0);
    csr_read("mcyc_hi", 12'hB80, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Time limit
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
